program_loader: RTL and testbench

- Boot-time sequencer that copies one of NUM_PROGS combinational program ROMs (4-bit address in, 8-bit instruction out) into the K2 instruction memory over a valid/ready write port.
- Sits between the program ROM bank (driven through rom_sel/rom_addr) and the instruction RAM write port.
- Holds the K2 core in reset while a load is in progress and releases it when the load completes.

---
 rtl/k2_loader_pkg.sv | 19 +
 rtl/program_loader.sv | 134 +++++++++++++
 tb/tb_program_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/k2_loader_pkg.sv
// k2_loader_pkg: shared types and constants for the K2 program loader.
//   loader_state_t : FSM state encoding (IDLE, FETCH, WRITE, DONE)
//   DEF_ADDR_W     : default instruction address width
//   DEF_DATA_W     : default instruction width
//   MAX_PROG_LEN   : longest program at the default address width
package k2_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int MAX_PROG_LEN = 2 ** DEF_ADDR_W;

endpackage

// File: rtl/program_loader.sv
// program_loader: boot-time sequencer that copies one of NUM_PROGS
// combinational program ROMs into the K2 instruction RAM and holds the
// core in reset until the copy is complete.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             load request (sampled only while idle)
//   prog_sel          program to load, latched on accepted start
//   prog_len          words to copy, latched (clamped to 2**ADDR_W)
//   rom_sel/rom_addr  registered ROM bank select and address
//   rom_data          combinational ROM output
//   mem_wr_*          valid/ready write port to the instruction RAM
//   busy              high from the cycle after accept until DONE exits
//   done              one-cycle completion pulse
//   cpu_rst_n         core reset, low while a load is in progress
//   checksum          8-bit modular sum of written words
//
// Build option: define LOADER_CHECKSUM_EN to synthesise the checksum
// accumulator; otherwise checksum is tied to 0.
module program_loader
  import k2_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_PROGS = 4,
  parameter int SEL_W     = $clog2(NUM_PROGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  prog_sel,
  input  logic [ADDR_W:0]   prog_len,
  output logic [SEL_W-1:0]  rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_rst_n,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t   state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] len_in;

  // Lengths beyond the memory size are clamped so a full load ends at the
  // top address instead of wrapping back over address 0.
  assign len_in = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  assign checksum = csum;
`else
  assign checksum = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_q        <= '0;
      rom_sel      <= '0;
      rom_addr     <= '0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cpu_rst_n    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rom_sel   <= prog_sel;
            len_q     <= len_in;
            rom_addr  <= '0;
            busy      <= 1'b1;
            cpu_rst_n <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
            if (len_in == '0) begin
              // Empty program: complete immediately, core released with done.
              state     <= DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          mem_wr_data  <= rom_data;
          mem_wr_addr  <= rom_addr;
          mem_wr_valid <= 1'b1;
          state        <= WRITE;
        end
        WRITE: begin
          // valid/addr/data stay registered and untouched until ready.
          if (mem_wr_ready) begin
            mem_wr_valid <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= csum + mem_wr_data;
`endif
            if ({1'b0, rom_addr} == len_q - ONE) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader.
// A transaction-level model expands each accepted load into the list of
// writes it must produce and tracks busy/done/cpu_rst_n/checksum from
// load events; a negedge process compares the DUT against it each cycle.
// Literal latency/checksum expectations pin the model on directed loads.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_program_loader;
  localparam int ADDR_W = 4, DATA_W = 8, NUM_PROGS = 4, SEL_W = 2;

  logic              clk, rst_n, start;
  logic [SEL_W-1:0]  prog_sel, rom_sel;
  logic [ADDR_W:0]   prog_len;
  logic [ADDR_W-1:0] rom_addr, mem_wr_addr;
  logic [DATA_W-1:0] rom_data, mem_wr_data, checksum;
  logic              mem_wr_valid, mem_wr_ready, busy, done, cpu_rst_n;

  logic [DATA_W-1:0] rom [NUM_PROGS][16];
  assign rom_data = rom[rom_sel][rom_addr];

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PROGS(NUM_PROGS), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_sel(prog_sel), .prog_len(prog_len),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .cpu_rst_n(cpu_rst_n), .checksum(checksum));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  wr_t               exp_q[$];
  bit                m_busy = 0, m_done = 0, m_cpu = 0;
  logic [DATA_W-1:0] m_csum = '0;
  bit                pend = 0;
  logic [ADDR_W-1:0] pa;
  logic [DATA_W-1:0] pd;
  int                hs_count = 0, a4_cycles = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 0; m_done = 0; m_cpu = 0; m_csum = '0; pend = 0;
    end else begin
      bit n_busy, n_done, n_cpu;
      int len;
      wr_t e;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_cpu));
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(m_csum));
`else
      chk("checksum_tied", 32'(checksum), 32'd0);
`endif
      if (pend) begin
        chk("hold_valid", 32'(mem_wr_valid), 32'd1);
        chk("hold_addr", 32'(mem_wr_addr), 32'(pa));
        chk("hold_data", 32'(mem_wr_data), 32'(pd));
      end
      if (!m_busy) chk("valid_when_idle", 32'(mem_wr_valid), 32'd0);
      if (mem_wr_valid && mem_wr_addr == 4'd4) a4_cycles++;

      n_busy = m_busy; n_done = 0; n_cpu = m_cpu;
      if (m_done) n_busy = 0;
      if (!m_busy && start) begin
        len = (prog_len > 16) ? 16 : int'(prog_len);
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
          logic [ADDR_W-1:0] ai;
          ai = ADDR_W'(i);
          e.a = ai; e.d = rom[prog_sel][ai];
          exp_q.push_back(e);
        end
        m_csum = '0; n_busy = 1; n_cpu = 0;
        if (len == 0) begin n_done = 1; n_cpu = 1; end
      end
      if (mem_wr_valid && mem_wr_ready) begin
        hs_count++;
        last_addr = mem_wr_addr;
        if (exp_q.size() == 0) begin
          chk("extra_write", 32'(mem_wr_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_wr_addr), 32'(e.a));
          chk("wr_data", 32'(mem_wr_data), 32'(e.d));
          m_csum = m_csum + e.d;
          if (exp_q.size() == 0) begin n_done = 1; n_cpu = 1; end
        end
      end
      pend = mem_wr_valid && !mem_wr_ready;
      pa = mem_wr_addr; pd = mem_wr_data;
      m_busy = n_busy; m_done = n_done; m_cpu = n_cpu;
    end
  end

  // ---------------- ready driver ----------------
  // 0: always ready, 1: random, 2: stall word 4 for 3 cycles, 3: stall word 5 forever
  int mode = 0, bp_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (mode)
      1: mem_wr_ready = ($urandom_range(0, 2) != 0);
      2: if (mem_wr_valid && mem_wr_addr == 4'd4 && bp_cnt < 3) begin
           mem_wr_ready = 1'b0; bp_cnt++;
         end else mem_wr_ready = 1'b1;
      3: mem_wr_ready = !(mem_wr_valid && mem_wr_addr == 4'd5);
      default: mem_wr_ready = 1'b1;
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [SEL_W-1:0] s, input logic [ADDR_W:0] l);
    @(posedge clk); #1;
    start = 1'b1; prog_sel = s; prog_len = l;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  // Returns the cycle (1 = first cycle after the start-sampling edge) done is seen.
  task automatic wait_done(output int lat, input int max_cyc);
    lat = -1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (done) begin lat = cyc - t0 + 1; return; end
    end
    checks++; errors++;
    $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rom_sel"}, 32'(rom_sel), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_valid"}, 32'(mem_wr_valid), 32'd0);
    chk({tag, "_wr_addr"}, 32'(mem_wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(mem_wr_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  initial begin
    int lat, h0, a0, k;
    logic [DATA_W-1:0] base [10];
    base = '{8'h08, 8'hf8, 8'h09, 8'hf9, 8'h0a, 8'hfa, 8'hd9, 8'hc9, 8'h04, 8'hf0};
    for (int b = 0; b < NUM_PROGS; b++)
      for (int i = 0; i < 16; i++) rom[b][i] = DATA_W'($urandom);
    for (int i = 0; i < 10; i++) rom[0][i] = base[i];

    rst_n = 1'b0; start = 1'b0; prog_sel = '0; prog_len = '0; mem_wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_after_reset", 32'(cpu_rst_n), 32'd0);

    // Basic load of bank 0, 10 words
    h0 = hs_count;
    do_start(2'd0, 5'd10);
    wait_done(lat, 100);
    chk("basic_latency", 32'(lat), 32'd21);
    chk("basic_cpu_rise", 32'(cpu_rst_n), 32'd1);
    chk("basic_writes", 32'(hs_count - h0), 32'd10);
`ifdef LOADER_CHECKSUM_EN
    chk("basic_checksum", 32'(checksum), 32'h9c);  // 10-word sum mod 256
`endif

    // Backpressure on word 4
    mode = 2; bp_cnt = 0; h0 = hs_count; a0 = a4_cycles;
    do_start(2'd0, 5'd10);
    wait_done(lat, 100);
    chk("bp_latency", 32'(lat), 32'd24);
    chk("bp_word4_cycles", 32'(a4_cycles - a0), 32'd4);
    chk("bp_writes", 32'(hs_count - h0), 32'd10);
    mode = 0;

    // Zero length
    h0 = hs_count;
    do_start(2'd1, 5'd0);
    wait_done(lat, 10);
    chk("len0_latency", 32'(lat), 32'd1);
    @(negedge clk);
    chk("len0_writes", 32'(hs_count - h0), 32'd0);

    // Over-length clamps to 16
    h0 = hs_count;
    do_start(2'd3, 5'd20);
    wait_done(lat, 100);
    chk("len20_latency", 32'(lat), 32'd33);
    chk("len20_writes", 32'(hs_count - h0), 32'd16);
    chk("len20_last_addr", 32'(last_addr), 32'd15);

    // start/sel/len churn during busy is ignored
    h0 = hs_count;
    do_start(2'd1, 5'd6);
    repeat (4) begin
      @(posedge clk); #1 start = 1'b1; prog_sel = 2'd3; prog_len = 5'd2;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(lat, 100);
    chk("busy_start_latency", 32'(lat), 32'd13);
    chk("busy_start_writes", 32'(hs_count - h0), 32'd6);

    // Reload from bank 2 while the core runs
    @(negedge clk);
    chk("core_running", 32'(cpu_rst_n), 32'd1);
    do_start(2'd2, 5'd8);
    @(negedge clk);
    chk("reload_core_held", 32'(cpu_rst_n), 32'd0);
    wait_done(lat, 100);
    chk("reload_latency", 32'(lat), 32'd17);

    // Randomized loads with random ready and busy-time start noise
    mode = 1;
    for (int n = 0; n < 10; n++) begin
      do_start(SEL_W'($urandom_range(0, 3)), 5'($urandom_range(0, 20)));
      k = 0;
      while (!done && k < 400) begin
        @(posedge clk); #1;
        start    = busy && ($urandom_range(0, 3) == 0);
        prog_sel = SEL_W'($urandom);
        prog_len = 5'($urandom_range(0, 31));
        k++;
      end
      start = 1'b0;
      if (k >= 400) begin
        checks++; errors++;
        $display("FAIL rand_timeout: load %0d did not finish", n);
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    // Asynchronous reset while word 5 is stalled in WRITE
    mode = 3;
    do_start(2'd0, 5'd10);
    k = 0;
    while (!(mem_wr_valid && mem_wr_addr == 4'd5) && k < 100) begin @(negedge clk); k++; end
    chk("reached_word5", 32'(mem_wr_addr), 32'd5);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_reset("midwrite_reset");
    @(posedge clk); #1 rst_n = 1'b1; mode = 0;
    do_start(2'd2, 5'd1);
    wait_done(lat, 20);
    chk("restart_latency", 32'(lat), 32'd3);
    chk("restart_addr0", 32'(last_addr), 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
